// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clk_div_pkg;

    localparam int CNT_W_DEFAULT = 28;

    typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

    function automatic cnt_t half_div(cnt_t d);
        return d >> 1;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/pending divisor, registered outputs.
// Optional runtime duty control is enabled with CLK_DIV_DUTY_CTRL_EN.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] div_i,
`ifdef CLK_DIV_DUTY_CTRL_EN
    input  logic [CNT_W-1:0] duty_i,
`endif
    output logic             clock_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] activeDiv_q, activeDiv_d;
    logic [CNT_W-1:0] pendDiv_q, pendDiv_d;
    logic             pendValid_q, pendValid_d;
    logic             clkOut_q, clkOut_d;
    logic             tick_q, tick_d;
    logic             wrap;
    logic             applyNow;
    logic             highNext;

`ifdef CLK_DIV_DUTY_CTRL_EN
    localparam logic [CNT_W-1:0] RESET_DUTY = CNT_W'(DEFAULT_DIV / 2);

    logic [CNT_W-1:0] activeDuty_q, activeDuty_d;
    logic [CNT_W-1:0] pendDuty_q, pendDuty_d;

    assign highNext = (cnt_q < activeDuty_q);
`else
    logic [CNT_W-1:0] halfDiv;

    if (CNT_W <= CNT_W_DEFAULT) begin : g_half_pkg
        assign halfDiv = CNT_W'(half_div(cnt_t'(activeDiv_q)));
    end else begin : g_half_wide
        assign halfDiv = activeDiv_q >> 1;
    end

    assign highNext = (activeDiv_q == CNT_W'(1)) || (cnt_q < halfDiv);
`endif

    // Divisors 0 and 1 wrap every edge so that a reload can never lock up.
    assign wrap     = (activeDiv_q < CNT_W'(2)) || (cnt_q >= activeDiv_q - CNT_W'(1));
    assign applyNow = !enable_i || wrap;

    always_comb begin
        cnt_d    = '0;
        clkOut_d = 1'b0;
        tick_d   = 1'b0;
        if (enable_i && (activeDiv_q != '0)) begin
            clkOut_d = highNext;
            tick_d   = (cnt_q == '0);
            if (!wrap) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // A load on an apply edge bypasses pending; otherwise it waits for the wrap.
    always_comb begin
        activeDiv_d = activeDiv_q;
        pendDiv_d   = pendDiv_q;
        pendValid_d = pendValid_q;
`ifdef CLK_DIV_DUTY_CTRL_EN
        activeDuty_d = activeDuty_q;
        pendDuty_d   = pendDuty_q;
`endif
        if (load_i) begin
            pendDiv_d = div_i;
`ifdef CLK_DIV_DUTY_CTRL_EN
            pendDuty_d = duty_i;
`endif
            if (applyNow) begin
                activeDiv_d = div_i;
`ifdef CLK_DIV_DUTY_CTRL_EN
                activeDuty_d = duty_i;
`endif
                pendValid_d = 1'b0;
            end else begin
                pendValid_d = 1'b1;
            end
        end else if (applyNow && pendValid_q) begin
            activeDiv_d = pendDiv_q;
`ifdef CLK_DIV_DUTY_CTRL_EN
            activeDuty_d = pendDuty_q;
`endif
            pendValid_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q       <= '0;
            activeDiv_q <= RESET_DIV;
            pendDiv_q   <= RESET_DIV;
            pendValid_q <= 1'b0;
            clkOut_q    <= 1'b0;
            tick_q      <= 1'b0;
`ifdef CLK_DIV_DUTY_CTRL_EN
            activeDuty_q <= RESET_DUTY;
            pendDuty_q   <= RESET_DUTY;
`endif
        end else begin
            cnt_q       <= cnt_d;
            activeDiv_q <= activeDiv_d;
            pendDiv_q   <= pendDiv_d;
            pendValid_q <= pendValid_d;
            clkOut_q    <= clkOut_d;
            tick_q      <= tick_d;
`ifdef CLK_DIV_DUTY_CTRL_EN
            activeDuty_q <= activeDuty_d;
            pendDuty_q   <= pendDuty_d;
`endif
        end
    end

    assign clock_o = clkOut_q;
    assign tick_o  = tick_q;

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent clock dividers sharing one load strobe.
// Define CLK_DIV_DUTY_CTRL_EN to add the per-channel duty input.
module multi_clock_divider
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                    clock_in,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enable,
    input  logic                    load,
    input  logic [NUM_CH*CNT_W-1:0] divisor,
`ifdef CLK_DIV_DUTY_CTRL_EN
    input  logic [NUM_CH*CNT_W-1:0] duty,
`endif
    output logic [NUM_CH-1:0]       clock_out,
    output logic [NUM_CH-1:0]       tick
);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        clk_div_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_channel (
            .clock_i  (clock_in),
            .reset_i  (reset),
            .enable_i (enable[ch]),
            .load_i   (load),
            .div_i    (divisor[ch*CNT_W +: CNT_W]),
`ifdef CLK_DIV_DUTY_CTRL_EN
            .duty_i   (duty[ch*CNT_W +: CNT_W]),
`endif
            .clock_o  (clock_out[ch]),
            .tick_o   (tick[ch])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider: reset, duty, reload, enable, D=0/1.
module tb_multi_clock_divider;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 28;

    logic                    clock_in;
    logic                    reset;
    logic [NUM_CH-1:0]       enable;
    logic                    load;
    logic [NUM_CH*CNT_W-1:0] divBus;
    logic [NUM_CH-1:0]       clock_out;
    logic [NUM_CH-1:0]       tick;
`ifdef CLK_DIV_DUTY_CTRL_EN
    logic [NUM_CH*CNT_W-1:0] dutyBus;
`endif

    int vectorCount = 0;
    int missCount   = 0;

    multi_clock_divider #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (2)
    ) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .divisor   (divBus),
`ifdef CLK_DIV_DUTY_CTRL_EN
        .duty      (dutyBus),
`endif
        .clock_out (clock_out),
        .tick      (tick)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive inputs, let one rising edge pass, and settle just after it.
    task automatic applyStimulus(input logic [NUM_CH-1:0] en, input logic ld);
        enable = en;
        load   = ld;
        @(posedge clock_in);
        #1;
        load = 1'b0;
    endtask

    task automatic setDiv(input int ch, input int d);
        divBus[ch*CNT_W +: CNT_W] = CNT_W'(d);
    endtask

`ifdef CLK_DIV_DUTY_CTRL_EN
    task automatic setDuty(input int ch, input int d);
        dutyBus[ch*CNT_W +: CNT_W] = CNT_W'(d);
    endtask
`endif

    // Patterns are listed first-edge-first from the MSB of the n-bit field;
    // channels other than ch must stay low.
    task automatic runPattern(input string tag, input int ch, input logic [NUM_CH-1:0] en,
                              input logic ldFirst, input int n,
                              input logic [63:0] clkPat, input logic [63:0] tickPat);
        logic [NUM_CH-1:0] expClk;
        logic [NUM_CH-1:0] expTick;
        for (int i = 0; i < n; i++) begin
            applyStimulus(en, ldFirst && (i == 0));
            expClk      = '0;
            expTick     = '0;
            expClk[ch]  = clkPat[n-1-i];
            expTick[ch] = tickPat[n-1-i];
            checkOutput(tag, 32'({clock_out, tick}), 32'({expClk, expTick}));
        end
    endtask

    initial begin
        int tickCnt;
        int highCnt;
        int firstTick;
        int lastTick;
        logic [NUM_CH-1:0] expClk;
        logic [NUM_CH-1:0] expTick;

        reset  = 1'b1;
        enable = '0;
        load   = 1'b0;
        for (int c = 0; c < NUM_CH; c++) setDiv(c, 2);
`ifdef CLK_DIV_DUTY_CTRL_EN
        dutyBus = '0;
`endif

        repeat (2) @(posedge clock_in);
        #1;
        checkOutput("rst_clk", 32'(clock_out), 32'h0);
        checkOutput("rst_tick", 32'(tick), 32'h0);
        reset = 1'b0;

        $display("[TB] ch0 D=4 then asynchronous reset mid-period");
        setDiv(0, 4);
        applyStimulus(4'b0000, 1'b1);
        runPattern("ch0_d4", 0, 4'b0001, 1'b0, 6, 'b110011, 'b100010);
        #3 reset = 1'b1;
        #1;
        checkOutput("rst_mid_async", 32'({clock_out, tick}), 32'h0);
        @(posedge clock_in);
        #1;
        checkOutput("rst_mid_held", 32'({clock_out, tick}), 32'h0);
        reset = 1'b0;
        runPattern("ch0_post_rst_d2", 0, 4'b0001, 1'b0, 4, 'b1010, 'b1010);

        $display("[TB] ch1 D=5 over 20 periods");
        setDiv(1, 5);
        applyStimulus(4'b0000, 1'b1);
        tickCnt   = 0;
        highCnt   = 0;
        firstTick = 0;
        lastTick  = 0;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(4'b0010, 1'b0);
            expClk  = ((i % 5) < 2)  ? 4'b0010 : 4'b0000;
            expTick = ((i % 5) == 0) ? 4'b0010 : 4'b0000;
            checkOutput("ch1_d5", 32'({clock_out, tick}), 32'({expClk, expTick}));
            if (tick[1]) begin
                if (tickCnt == 0) firstTick = i;
                lastTick = i;
                tickCnt++;
            end
            if (clock_out[1]) highCnt++;
        end
        checkOutput("ch1_ticks", 32'(tickCnt), 32'd20);
        checkOutput("ch1_high", 32'(highCnt), 32'd40);
        checkOutput("ch1_span", 32'(lastTick - firstTick), 32'd95);

        $display("[TB] ch1 enable drop mid-period and restart");
        runPattern("ch1_mid", 1, 4'b0010, 1'b0, 2, 'b11, 'b10);
        runPattern("ch1_off", 1, 4'b0000, 1'b0, 2, 'b00, 'b00);
        runPattern("ch1_restart", 1, 4'b0010, 1'b0, 5, 'b11000, 'b10000);

        $display("[TB] ch2 D=6 reloaded to 2 mid-period");
        setDiv(2, 6);
        applyStimulus(4'b0000, 1'b1);
        runPattern("ch2_d6", 2, 4'b0100, 1'b0, 1, 'b1, 'b1);
        setDiv(2, 2);
        runPattern("ch2_reload", 2, 4'b0100, 1'b1, 11, 'b11000101010, 'b00000101010);

        $display("[TB] ch0 load on wrap edge, then double load");
        setDiv(0, 4);
        applyStimulus(4'b0000, 1'b1);
        runPattern("ch0_pre_wrap", 0, 4'b0001, 1'b0, 3, 'b110, 'b100);
        setDiv(0, 8);
        runPattern("ch0_wrap_load", 0, 4'b0001, 1'b1, 10, 'b0111100001, 'b0100000001);
        setDiv(0, 3);
        runPattern("ch0_load_first", 0, 4'b0001, 1'b1, 2, 'b11, 'b00);
        setDiv(0, 6);
        runPattern("ch0_load_last", 0, 4'b0001, 1'b1, 12, 'b100001110001, 'b000001000001);

        $display("[TB] ch3 D=0 idle, then D=1");
        setDiv(3, 0);
        applyStimulus(4'b0000, 1'b1);
        runPattern("ch3_d0", 3, 4'b1000, 1'b0, 6, 'b000000, 'b000000);
        setDiv(3, 1);
        runPattern("ch3_d1", 3, 4'b1000, 1'b1, 6, 'b011111, 'b011111);

`ifdef CLK_DIV_DUTY_CTRL_EN
        $display("[TB] ch0 duty control with D=10");
        setDiv(0, 10);
        setDuty(0, 3);
        applyStimulus(4'b0000, 1'b1);
        runPattern("duty_3", 0, 4'b0001, 1'b0, 10, 'b1110000000, 'b1000000000);
        setDuty(0, 12);
        applyStimulus(4'b0000, 1'b1);
        runPattern("duty_12", 0, 4'b0001, 1'b0, 10, 'b1111111111, 'b1000000000);
        setDuty(0, 0);
        applyStimulus(4'b0000, 1'b1);
        runPattern("duty_0", 0, 4'b0001, 1'b0, 10, 'b0000000000, 'b1000000000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
